lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller for a 128x32 little-endian data memory with a combinational read port.
// Handles byte/half/word loads with sign/zero extension and sub-word stores by read-modify-write.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        misalign,
    output logic        dm_we,
    output logic [6:0]  dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, ERR, FIN} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        sx_q;
    logic [31:0] merge_q;
    logic        done_q;
    logic        busy_q;
    logic        mis_q;
    logic        we_q;

    logic        mis_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        mis_in = (size == 2'b11)
               | ((size == 2'b01) & addr[0])
               | ((size == 2'b10) & (addr[1:0] != 2'b00));
    end

    always_comb begin
        byte_sel = dm_dout[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (size_q)
            2'b00:   load_val = {{24{sx_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{sx_q & half_sel[15]}}, half_sel};
            default: load_val = dm_dout;
        endcase
    end

    // merge_q holds the right-aligned store data until RMW_RD folds it into the read word
    always_comb begin
        merged = dm_dout;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = merge_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = merge_q[15:0];
    end

    // Output flags are registered alongside the state and describe the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdata   <= '0;
            dm_addr <= '0;
            merge_q <= '0;
            size_q  <= '0;
            lane_q  <= '0;
            sx_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    mis_q  <= 1'b0;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    if (req) begin
                        dm_addr <= addr[8:2];
                        size_q  <= size;
                        lane_q  <= addr[1:0];
                        sx_q    <= sign_ext;
                        merge_q <= wdata;
                        busy_q  <= 1'b1;
                        if (mis_in) begin
                            state <= ERR;
                        end else if (!we) begin
                            state <= LD;
                        end else if (size == 2'b10) begin
                            state <= WR;
                            we_q  <= 1'b1;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LD: begin
                    rdata  <= load_val;
                    done_q <= 1'b1;
                    state  <= FIN;
                end
                RMW_RD: begin
                    merge_q <= merged;
                    we_q    <= 1'b1;
                    state   <= WR;
                end
                WR: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b1;
                    state  <= FIN;
                end
                ERR: begin
                    done_q <= 1'b1;
                    mis_q  <= 1'b1;
                    state  <= FIN;
                end
                FIN: begin
                    done_q <= 1'b0;
                    mis_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    mis_q  <= 1'b0;
                    busy_q <= 1'b0;
                    we_q   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Gating with rst_n keeps a reset cycle from writing memory or signalling completion
    assign done     = done_q & rst_n;
    assign busy     = busy_q & rst_n;
    assign misalign = mis_q & rst_n;
    assign dm_we    = we_q & rst_n;
    assign dm_din   = merge_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a vector table of single accesses plus hand-written
// sequences for reset, mid-RMW reset abort and requests arriving while busy.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        misalign;
    logic        dm_we;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:127];
    logic        pl_en;
    logic [6:0]  pl_idx;
    logic [31:0] pl_val;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .done     (done),
        .busy     (busy),
        .misalign (misalign),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_dout  (dm_dout)
    );

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (dm_we)
            mem[dm_addr] <= dm_din;
    end
    assign dm_dout = mem[dm_addr];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v, output int done_cyc, output logic mis,
                             output int we_cnt, output logic busy1, output logic done_after);
        int cyc;
        @(negedge clk);
        req = 1'b1; we = v.we; size = v.size; sign_ext = v.sx; addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        req = 1'b0;
        busy1 = busy;
        cyc = 1; done_cyc = 0; we_cnt = 0; mis = 1'b0;
        while (cyc <= 8 && done_cyc == 0) begin
            if (dm_we) we_cnt++;
            if (done) begin
                done_cyc = cyc;
                mis = misalign;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, wc, n_done, n_we;
        logic m, b1, da;
        vec_t v;

        //          we    size   sx    addr    wdata         rdata         mis  lat we  mem
        tbl[0]  = '{1'b0, 2'b00, 1'b1, 9'h017, 32'h0,        32'hFFFFFF88, 1'b0, 2, 0, 32'h8899AABB};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 9'h017, 32'h0,        32'h00000088, 1'b0, 2, 0, 32'h8899AABB};
        tbl[2]  = '{1'b0, 2'b01, 1'b1, 9'h016, 32'h0,        32'hFFFF8899, 1'b0, 2, 0, 32'h8899AABB};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 9'h014, 32'h0,        32'h8899AABB, 1'b0, 2, 0, 32'h8899AABB};
        tbl[4]  = '{1'b1, 2'b00, 1'b0, 9'h015, 32'hFFFFFF5A, 32'h8899AABB, 1'b0, 3, 1, 32'h88995ABB};
        tbl[5]  = '{1'b0, 2'b10, 1'b0, 9'h014, 32'h0,        32'h88995ABB, 1'b0, 2, 0, 32'h88995ABB};
        tbl[6]  = '{1'b0, 2'b10, 1'b0, 9'h016, 32'h0,        32'h88995ABB, 1'b1, 2, 0, 32'h88995ABB};
        tbl[7]  = '{1'b0, 2'b01, 1'b0, 9'h015, 32'h0,        32'h88995ABB, 1'b1, 2, 0, 32'h88995ABB};
        tbl[8]  = '{1'b0, 2'b11, 1'b0, 9'h014, 32'h0,        32'h88995ABB, 1'b1, 2, 0, 32'h88995ABB};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 9'h014, 32'hABCD1234, 32'h88995ABB, 1'b0, 3, 1, 32'h88991234};
        tbl[10] = '{1'b1, 2'b10, 1'b0, 9'h018, 32'hDEADBEEF, 32'h88995ABB, 1'b0, 2, 1, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 2'b00, 1'b1, 9'h019, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 0, 32'hDEADBEEF};
        tbl[12] = '{1'b0, 2'b01, 1'b0, 9'h018, 32'h0,        32'h0000BEEF, 1'b0, 2, 0, 32'hDEADBEEF};
        tbl[13] = '{1'b1, 2'b10, 1'b0, 9'h01A, 32'h12345678, 32'h0000BEEF, 1'b1, 2, 0, 32'hDEADBEEF};
        tbl[14] = '{1'b0, 2'b00, 1'b1, 9'h014, 32'h0,        32'h00000034, 1'b0, 2, 0, 32'h88991234};
        tbl[15] = '{1'b1, 2'b00, 1'b0, 9'h1FF, 32'h00000080, 32'h00000034, 1'b0, 3, 1, 32'h80000000};
        tbl[16] = '{1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0,        32'h80000000, 1'b0, 2, 0, 32'h80000000};
        tbl[17] = '{1'b0, 2'b00, 1'b1, 9'h1FF, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h80000000};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; pl_en = 1'b1; pl_idx = '0; pl_val = '0;

        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            pl_idx = 7'(i);
            pl_val = (i == 5) ? 32'h8899AABB : 32'h0;
        end
        @(negedge clk);
        pl_en = 1'b0;

        chk("rst_done",  {31'b0, done},     32'h0);
        chk("rst_busy",  {31'b0, busy},     32'h0);
        chk("rst_mis",   {31'b0, misalign}, 32'h0);
        chk("rst_dm_we", {31'b0, dm_we},    32'h0);
        chk("rst_rdata", rdata,             32'h0);
        chk("rst_dmaddr", {25'b0, dm_addr}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", {31'b0, busy}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            v = tbl[i];
            do_access(v, dc, m, wc, b1, da);
            chk($sformatf("v%0d_latency", i), 32'(dc), 32'(v.exp_lat));
            chk($sformatf("v%0d_misalign", i), {31'b0, m}, {31'b0, v.exp_mis});
            chk($sformatf("v%0d_we_pulses", i), 32'(wc), 32'(v.exp_we));
            chk($sformatf("v%0d_busy", i), {31'b0, b1}, 32'h1);
            chk($sformatf("v%0d_done_1cyc", i), {31'b0, da}, 32'h0);
            chk($sformatf("v%0d_rdata", i), rdata, v.exp_rdata);
            chk($sformatf("v%0d_mem", i), mem[v.addr[8:2]], v.exp_mem);
        end

        // Requests held high while busy (and in FIN) must be ignored
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 9'h014; wdata = 32'h00000011;
        @(posedge clk); #1;
        size = 2'b10; addr = 9'h01C; wdata = 32'hCAFEF00D;
        n_done = 0; n_we = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) n_done++;
            if (dm_we) n_we++;
            @(posedge clk); #1;
            if (c == 2) req = 1'b0;
        end
        chk("busy_req_done_cnt", 32'(n_done), 32'd1);
        chk("busy_req_we_cnt", 32'(n_we), 32'd1);
        chk("busy_req_word7", mem[7], 32'h0);
        chk("busy_req_word5", mem[5], 32'h88991211);

        // Reset asserted during RMW_RD of a byte store aborts the access
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 9'h015; wdata = 32'h00000077;
        @(posedge clk); #1;
        req = 1'b0;
        chk("rmw_rst_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_busy_gated", {31'b0, busy}, 32'h0);
        chk("rmw_rst_we_gated", {31'b0, dm_we}, 32'h0);
        chk("rmw_rst_done_gated", {31'b0, done}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0; n_we = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (dm_we) n_we++;
        end
        chk("rmw_rst_done_cnt", 32'(n_done), 32'd0);
        chk("rmw_rst_we_cnt", 32'(n_we), 32'd0);
        chk("rmw_rst_idle", {31'b0, busy}, 32'h0);
        chk("rmw_rst_word5", mem[5], 32'h88991211);
        chk("rmw_rst_rdata", rdata, 32'h0);
        chk("rmw_rst_dmaddr", {25'b0, dm_addr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
